// File: rtl/alu_control_pipe.sv
// Registered ALU control stage between ID/EX and the ALU: decodes {ALUOp, funct},
// registers the result with stall/flush handling, and tracks the multi-cycle mul/div unit.
module alu_control_pipe #(
  parameter int OP_WIDTH      = 4,
  parameter int MD_CYCLES     = 8,
  parameter int ENABLE_MULDIV = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_in,
  input  logic [2:0]          alu_op_in,
  input  logic [5:0]          funct_in,
  input  logic                stall_in,
  input  logic                flush_in,
  output logic [OP_WIDTH-1:0] alu_operation,
  output logic                jr_sel,
  output logic                valid_out,
  output logic                illegal_out,
  output logic                stall_out,
  output logic                md_busy,
  output logic                md_done
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_NOR  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_LUI  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_JR   = 4'b1000;
  localparam logic [3:0] OP_ILL  = 4'b1001;
  localparam logic [3:0] OP_SLT  = 4'b1010;
  localparam logic [3:0] OP_MULT = 4'b1011;
  localparam logic [3:0] OP_DIV  = 4'b1100;
  localparam logic [3:0] OP_MFHI = 4'b1101;
  localparam logic [3:0] OP_MFLO = 4'b1110;

  localparam logic [OP_WIDTH-1:0] OP_ILL_EXT = OP_WIDTH'(OP_ILL);
  localparam logic [7:0]          MD_LOAD    = 8'(MD_CYCLES);
  localparam logic                MD_EN      = (ENABLE_MULDIV != 0);

  logic [3:0]          dec_code;
  logic [OP_WIDTH-1:0] dec_ext;
  logic                dec_jr;
  logic                md_class;
  logic                md_issue;
  logic                md_load;
  logic                stall_req;

  logic [OP_WIDTH-1:0] op_reg;
  logic                jr_reg;
  logic                valid_reg;
  logic [7:0]          md_count_reg;
  logic                md_done_reg;

  always_comb begin
    dec_code = OP_ILL;
    case (alu_op_in)
      3'b111: begin
        case (funct_in)
          6'b100100: dec_code = OP_AND;
          6'b100101: dec_code = OP_OR;
          6'b100111: dec_code = OP_NOR;
          6'b100000: dec_code = OP_ADD;
          6'b100010: dec_code = OP_SUB;
          6'b000010: dec_code = OP_SRL;
          6'b000000: dec_code = OP_SLL;
          6'b001000: dec_code = OP_JR;
          6'b101010: dec_code = OP_SLT;
          6'b011000: dec_code = MD_EN ? OP_MULT : OP_ILL;
          6'b011010: dec_code = MD_EN ? OP_DIV  : OP_ILL;
          6'b010000: dec_code = MD_EN ? OP_MFHI : OP_ILL;
          6'b010010: dec_code = MD_EN ? OP_MFLO : OP_ILL;
          default:   dec_code = OP_ILL;
        endcase
      end
      3'b110:  dec_code = OP_ADD;
      3'b101:  dec_code = OP_OR;
      3'b001:  dec_code = OP_AND;
      3'b010:  dec_code = OP_ADD;
      3'b011:  dec_code = OP_ADD;
      3'b100:  dec_code = OP_LUI;
      3'b000:  dec_code = OP_SUB;
      default: dec_code = OP_ILL;
    endcase
  end

  // Zero-extend the 4-bit code into the configurable output width.
  genvar gi;
  generate
    for (gi = 0; gi < OP_WIDTH; gi++) begin : g_ext
      if (gi < 4) begin : g_low
        assign dec_ext[gi] = dec_code[gi];
      end else begin : g_high
        assign dec_ext[gi] = 1'b0;
      end
    end
  endgenerate

  assign dec_jr   = (dec_code == OP_JR);
  assign md_class = MD_EN && ((dec_code == OP_MULT) || (dec_code == OP_DIV) ||
                              (dec_code == OP_MFHI) || (dec_code == OP_MFLO));
  assign md_issue = MD_EN && ((dec_code == OP_MULT) || (dec_code == OP_DIV));

  assign md_busy   = (md_count_reg != 8'd0);
  assign stall_req = valid_in & md_class & md_busy & ~flush_in;
  // A load only happens when no stall is pending, so the counter is idle at that point.
  assign md_load   = ~flush_in & ~stall_in & ~stall_req & valid_in & md_issue;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg    <= 1'b0;
      op_reg       <= '0;
      jr_reg       <= 1'b0;
      md_count_reg <= 8'd0;
      md_done_reg  <= 1'b0;
    end else begin
      md_done_reg <= (md_count_reg == 8'd1);

      if (flush_in) begin
        valid_reg <= 1'b0;
        op_reg    <= '0;
        jr_reg    <= 1'b0;
      end else if (!stall_in) begin
        if (stall_req) begin
          valid_reg <= 1'b0;
          op_reg    <= '0;
          jr_reg    <= 1'b0;
        end else begin
          valid_reg <= valid_in;
          op_reg    <= dec_ext;
          jr_reg    <= dec_jr;
        end
      end

      if (md_load) begin
        md_count_reg <= MD_LOAD;
      end else if (md_count_reg != 8'd0) begin
        md_count_reg <= md_count_reg - 8'd1;
      end
    end
  end

  assign alu_operation = op_reg;
  assign jr_sel        = jr_reg;
  assign valid_out     = valid_reg;
  assign illegal_out   = valid_reg & (op_reg == OP_ILL_EXT);
  assign stall_out     = stall_req;
  assign md_done       = md_done_reg;

endmodule

// File: tb/tb_alu_control_pipe.sv
// Directed bench for alu_control_pipe: expectations are queued when each step is driven
// and compared after the capturing clock edge.
module tb_alu_control_pipe;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid_in = 1'b0;
  logic [2:0] alu_op_in = 3'b111;
  logic [5:0] funct_in = 6'b100000;
  logic       stall_in = 1'b0;
  logic       flush_in = 1'b0;

  logic [3:0] alu_operation;
  logic       jr_sel, valid_out, illegal_out, stall_out, md_busy, md_done;

  logic [5:0] alu_operation0;
  logic       jr_sel0, valid_out0, illegal_out0, stall_out0, md_busy0, md_done0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic       v;
    logic [3:0] op;
    logic       jr;
    logic       ill;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alu_control_pipe #(.OP_WIDTH(4), .MD_CYCLES(8), .ENABLE_MULDIV(1)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .alu_op_in(alu_op_in),
    .funct_in(funct_in), .stall_in(stall_in), .flush_in(flush_in),
    .alu_operation(alu_operation), .jr_sel(jr_sel), .valid_out(valid_out),
    .illegal_out(illegal_out), .stall_out(stall_out), .md_busy(md_busy),
    .md_done(md_done)
  );

  // Mul/div disabled, wider op code: shares the stimulus of the main instance.
  alu_control_pipe #(.OP_WIDTH(6), .MD_CYCLES(8), .ENABLE_MULDIV(0)) dut0 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .alu_op_in(alu_op_in),
    .funct_in(funct_in), .stall_in(stall_in), .flush_in(flush_in),
    .alu_operation(alu_operation0), .jr_sel(jr_sel0), .valid_out(valid_out0),
    .illegal_out(illegal_out0), .stall_out(stall_out0), .md_busy(md_busy0),
    .md_done(md_done0)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input string tag, input logic v, input logic [2:0] aop,
                      input logic [5:0] f, input logic st, input logic fl,
                      input logic e_stall, input logic ev, input logic [3:0] eop,
                      input logic ejr, input logic ebusy, input logic edone);
    exp_t e;
    @(negedge clk);
    valid_in  = v;
    alu_op_in = aop;
    funct_in  = f;
    stall_in  = st;
    flush_in  = fl;
    #1;
    chk({tag, ".stall_out"}, {7'd0, stall_out}, {7'd0, e_stall});
    e.tag = tag; e.v = ev; e.op = eop; e.jr = ejr;
    e.ill = ev & (eop == 4'b1001); e.busy = ebusy; e.done = edone;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".valid_out"}, {7'd0, valid_out}, {7'd0, e.v});
    chk({e.tag, ".alu_operation"}, {4'd0, alu_operation}, {4'd0, e.op});
    chk({e.tag, ".jr_sel"}, {7'd0, jr_sel}, {7'd0, e.jr});
    chk({e.tag, ".illegal_out"}, {7'd0, illegal_out}, {7'd0, e.ill});
    chk({e.tag, ".md_busy"}, {7'd0, md_busy}, {7'd0, e.busy});
    chk({e.tag, ".md_done"}, {7'd0, md_done}, {7'd0, e.done});
    $display("txn %s v=%b op=%b st=%b fl=%b -> valid=%b alu_op=%h jr=%b ill=%b busy=%b done=%b",
             e.tag, v, aop, st, fl, valid_out, alu_operation, jr_sel, illegal_out, md_busy, md_done);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset.valid_out", {7'd0, valid_out}, 8'd0);
    chk("reset.alu_operation", {4'd0, alu_operation}, 8'd0);
    chk("reset.jr_sel", {7'd0, jr_sel}, 8'd0);
    chk("reset.illegal_out", {7'd0, illegal_out}, 8'd0);
    chk("reset.md_busy", {7'd0, md_busy}, 8'd0);
    chk("reset.md_done", {7'd0, md_done}, 8'd0);

    //    tag     v  aluop   funct      st fl es ev op       jr busy done
    step("add",   1, 3'b111, 6'b100000, 0, 0, 0, 1, 4'b0011, 0, 0, 0);
    step("jr",    1, 3'b111, 6'b001000, 0, 0, 0, 1, 4'b1000, 1, 0, 0);
    step("illeg", 1, 3'b111, 6'b111111, 0, 0, 0, 1, 4'b1001, 0, 0, 0);
    step("slt",   1, 3'b111, 6'b101010, 0, 0, 0, 1, 4'b1010, 0, 0, 0);
    step("sub",   1, 3'b111, 6'b100010, 0, 0, 0, 1, 4'b0100, 0, 0, 0);
    step("nor",   1, 3'b111, 6'b100111, 0, 0, 0, 1, 4'b0010, 0, 0, 0);
    step("beq",   1, 3'b000, 6'b111111, 0, 0, 0, 1, 4'b0100, 0, 0, 0);
    step("lui",   1, 3'b100, 6'b100000, 0, 0, 0, 1, 4'b0101, 0, 0, 0);
    step("ori",   1, 3'b101, 6'b001000, 0, 0, 0, 1, 4'b0001, 0, 0, 0);

    // MULT issue, then MFLO waits out the busy window behind bubbles.
    step("mult",  1, 3'b111, 6'b011000, 0, 0, 0, 1, 4'b1011, 0, 1, 0);
    chk("nomd.alu_operation", {2'd0, alu_operation0}, 8'h09);
    chk("nomd.illegal_out", {7'd0, illegal_out0}, 8'd1);
    chk("nomd.md_busy", {7'd0, md_busy0}, 8'd0);
    for (int i = 0; i < 8; i++) begin
      step($sformatf("mflo_wait%0d", i), 1, 3'b111, 6'b010010, 0, 0,
           1, 0, 4'b0000, 0, (i < 7), (i == 7));
      if (i == 0) begin
        chk("nomd.stall_out", {7'd0, stall_out0}, 8'd0);
        chk("nomd.mflo_illegal", {2'd0, alu_operation0}, 8'h09);
      end
    end
    step("mflo",  1, 3'b111, 6'b010010, 0, 0, 0, 1, 4'b1110, 0, 0, 0);

    // Downstream stall holds the stage; ADD appears once after release.
    for (int i = 0; i < 3; i++)
      step($sformatf("hold%0d", i), 1, 3'b111, 6'b100000, 1, 0, 0, 1, 4'b1110, 0, 0, 0);
    step("add_rel", 1, 3'b111, 6'b100000, 0, 0, 0, 1, 4'b0011, 0, 0, 0);
    step("idle",    0, 3'b111, 6'b100000, 0, 0, 0, 0, 4'b0011, 0, 0, 0);

    // A flushed MULT must not start the counter.
    step("mult_fl", 1, 3'b111, 6'b011000, 0, 1, 0, 0, 4'b0000, 0, 0, 0);
    step("idle2",   0, 3'b111, 6'b100000, 0, 0, 0, 0, 4'b0011, 0, 0, 0);

    // Flush during a running count: counter keeps draining to zero.
    step("mult2",   1, 3'b111, 6'b011000, 0, 0, 0, 1, 4'b1011, 0, 1, 0);
    step("mfhi_fl", 1, 3'b111, 6'b010000, 0, 1, 0, 0, 4'b0000, 0, 1, 0);
    for (int i = 0; i < 7; i++)
      step($sformatf("drain%0d", i), 0, 3'b111, 6'b100000, 0, 0,
           0, 0, 4'b0011, 0, (i < 6), (i == 6));
    step("div",     1, 3'b111, 6'b011010, 0, 0, 0, 1, 4'b1100, 0, 1, 0);
    chk("nomd.div_busy", {7'd0, md_busy0}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_control_pipe.md
Name: alu_control_pipe

Overview:
Registered, parametrised ALU control unit for the pipelined MIPS core, sitting between the ID/EX boundary and the ALU. It decodes {ALUOp, funct} into an ALU operation code and JR select, as the existing combinational decoder does. It also registers the result with valid/stall/flush handling, and adds SLT plus multi-cycle MULT/DIV/MFHI/MFLO support. A busy counter drives a structural-hazard stall request.

Parameters:
OP_WIDTH, 4, width of alu_operation; must be >=4; upper bits are zero-extended.
MD_CYCLES, 8, number of cycles the MULT/DIV unit is busy after issue; legal range 2..255.
ENABLE_MULDIV, 1, 1 = decode MULT/DIV/MFHI/MFLO; 0 = these decode as illegal.

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-high reset
valid_in  input  1  ID stage holds a valid instruction
alu_op_in  input  3  ALUOp from main control
funct_in  input  6  instruction funct field
stall_in  input  1  downstream hazard stall; hold the registered stage
flush_in  input  1  kill the instruction entering EX
alu_operation  output  OP_WIDTH  registered ALU operation code
jr_sel  output  1  registered; 1 when the operation is JR
valid_out  output  1  registered; EX-stage instruction is valid
illegal_out  output  1  valid_out & (alu_operation == 4'b1001)
stall_out  output  1  combinational; request ID/IF to hold because of a mul/div structural hazard
md_busy  output  1  multiply/divide unit occupied (md_count != 0)
md_done  output  1  one-cycle pulse when md_count goes 1->0

Behaviour:
- Decode (combinational, ALUOp=111 selects R-type by funct):
  - AND 100100->0000; OR 100101->0001; NOR 100111->0010; ADD 100000->0011; SUB 100010->0100.
  - SRL 000010->0110; SLL 000000->0111; JR 001000->1000; SLT 101010->1010.
  - MULT 011000->1011; DIV 011010->1100; MFHI 010000->1101; MFLO 010010->1110.
  - ALUOp 110 ADDI->0011; 101 ORI->0001; 001 ANDI->0000; 010 SW->0011; 011 LW->0011; 100 LUI->0101; 000 branch->0100. Funct is ignored for these.
  - Any other combination decodes to 1001 (illegal).
  - jr_sel = decoded code == 1000.
- md_class = decoded code in {1011,1100,1101,1110} and ENABLE_MULDIV=1.
- stall_out = valid_in & md_class & md_busy & ~flush_in.
- Stage register update, in priority order:
  - reset: valid_out=0, alu_operation=0, jr_sel=0, md_count=0, md_done=0.
  - else if flush_in: valid_out<=0. Operation and jr_sel are don't-care but are cleared to 0.
  - else if stall_in: all stage registers hold.
  - else if stall_out: insert a bubble: valid_out<=0, alu_operation<=0, jr_sel<=0.
  - else: valid_out<=valid_in, alu_operation<=decoded, jr_sel<=decoded JR.
- Latency: one clock from valid_in to valid_out.
- Busy counter md_count, 8 bits:
  - Loads MD_CYCLES when a MULT or DIV is captured into the stage register (last branch above with valid_in=1).
  - Otherwise decrements by 1 whenever nonzero, including during stall_in and flush.
  - md_done registered = (md_count==1) at the clock edge.
- MFHI/MFLO do not load the counter. They only stall while md_busy=1.
- A flushed MULT/DIV never loads the counter. Flush does not cancel a counter already running.
- Simultaneous load and decrement cannot occur, because a load requires md_busy=0.
- ENABLE_MULDIV=0: md_class is never true, stall_out is 0, md_count stays 0, and mul/div functs are illegal.

Test Plan:
- Reset held 2 cycles, then released -> all outputs 0. Then apply valid_in=1, ALUOp=111, funct=100000 -> next cycle valid_out=1, alu_operation=0011, jr_sel=0.
- ALUOp=111, funct=001000 -> alu_operation=1000, jr_sel=1. ALUOp=111, funct=111111 -> alu_operation=1001, illegal_out=1.
- MULT issued (MD_CYCLES=8), then MFLO next cycle:
  - md_busy=1 for 8 cycles and stall_out=1 while busy.
  - Bubbles (valid_out=0) are inserted.
  - md_done pulses once.
  - MFLO is captured (alu_operation=1110) the cycle after md_busy falls.
- ADD with stall_in=1 for 3 cycles -> stage outputs hold their previous values. After release, ADD appears with valid_out=1 exactly once.
- MULT with flush_in=1 -> valid_out=0 and md_count stays 0. Also flush during a running count -> the count continues to 0.
- ENABLE_MULDIV=0, funct=011000 -> alu_operation=1001, stall_out=0, md_busy=0.
